pixel_fetch_responder: RTL
==========================

PIXEL_FETCH_RESPONDER -- requirements
Module: pixel_fetch_responder

Interface
REQ-001 Parameters SHALL be: ROW_NUM=480 (frame rows); COL_NUM=640 (frame columns); ADDR_W=32 (memory address width); BASE_ADDR=0 (frame byte base address); TIMEOUT_CYCLES=255 (fetch timeout, used only with FETCH_TIMEOUT_EN).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports, in order (name, direction, width, meaning), SHALL be:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  enables the serving of pixel requests.
- req_x  in  11  requested column, signed.
- req_y  in  11  requested row, signed.
- waitrequest  out  1  0 means pixel is valid for req_x/req_y this cycle.
- pixel  out  8  returned pixel.
- mem_read  out  1  memory read strobe.
- mem_address  out  ADDR_W  byte address.
- mem_waitrequest  in  1  memory stalls the read.
- mem_readdatavalid  in  1  mem_readdata is valid.
- mem_readdata  in  8  memory data.
- fetch_error  out  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have the states IDLE, LOOKUP, MEM_REQ, MEM_WAIT and PRESENT.
REQ-005 IDLE SHALL go to LOOKUP when en=1 and stay in IDLE otherwise; waitrequest SHALL be 1 in every state except PRESENT.
REQ-006 LOOKUP SHALL latch req_x/req_y; a coordinate is out of range when x<0, x>=COL_NUM, y<0 or y>=ROW_NUM.
REQ-007 From LOOKUP, an out-of-range request SHALL load a data register with 0 and go to PRESENT, with no memory access; an in-range request SHALL go to MEM_REQ.
REQ-008 In MEM_REQ, mem_read SHALL be 1 and mem_address SHALL be BASE_ADDR + y*COL_NUM + x, computed at ADDR_W bits from the latched coordinates; the FSM SHALL leave for MEM_WAIT at the first edge with mem_waitrequest=0.
REQ-009 In MEM_WAIT, mem_read SHALL be 0; on mem_readdatavalid=1 the block SHALL latch mem_readdata and go to PRESENT.
REQ-010 If mem_readdatavalid arrives in the same cycle the read is accepted in MEM_REQ, the block SHALL latch the data and go directly to PRESENT.
REQ-011 PRESENT SHALL last exactly one cycle with waitrequest=0 and pixel driven from the data register, then go to LOOKUP if en=1, else to IDLE.
REQ-012 The pixel output SHALL hold the last presented value in all other states.
REQ-013 The requester holds req_x/req_y stable while waitrequest=1; coordinates are sampled only in LOOKUP.
REQ-014 Deasserting en during MEM_REQ or MEM_WAIT SHALL NOT abort the fetch; the pixel SHALL still be presented, then the FSM SHALL go to IDLE.
REQ-015 Minimum latency SHALL be 2 cycles from LOOKUP to PRESENT for an out-of-range request, and 4 cycles for an in-range request with zero memory wait and readdatavalid one cycle after acceptance.

Reset
REQ-016 With rst=0, the block SHALL asynchronously reset state to IDLE, waitrequest to 1, pixel to 0, mem_read to 0, mem_address to 0, fetch_error to 0 and the latched coordinates to 0.
REQ-017 A reset during MEM_REQ or MEM_WAIT SHALL drop mem_read immediately, and any later mem_readdatavalid SHALL be ignored while in IDLE or LOOKUP.

Configuration
REQ-018 With the macro FETCH_TIMEOUT_EN defined, a counter SHALL clear on entering MEM_REQ and increment every cycle in MEM_REQ or MEM_WAIT.
REQ-019 With FETCH_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL load data 0, go to PRESENT and set fetch_error=1, which stays set until reset.
REQ-020 Without FETCH_TIMEOUT_EN, no counter SHALL exist, the block SHALL wait on memory indefinitely, and fetch_error SHALL be tied to 0 (port retained).

Verification
REQ-021 The bench SHALL check: en=1, req=(5,2), memory with zero wait returns 0xA7 one cycle later -> mem_address=0x505 in MEM_REQ, then one cycle of waitrequest=0 with pixel=0xA7, 4 cycles after LOOKUP.
REQ-022 The bench SHALL check: req=(640,0), then req=(-1,3), then req=(0,480) -> pixel=0 each time, no mem_read, waitrequest=0 two cycles after each LOOKUP.
REQ-023 The bench SHALL check: mem_waitrequest held high for 3 cycles at req=(0,0) -> mem_read=1 and mem_address=0 stable for 4 cycles, then the correct pixel is presented.
REQ-024 The bench SHALL check: en dropped to 0 during MEM_WAIT -> the pixel is still presented once, then IDLE with waitrequest=1.
REQ-025 The bench SHALL check: rst=0 mid-MEM_REQ -> mem_read=0 and waitrequest=1 in the same cycle, and a stray readdatavalid does not change pixel.
REQ-026 The bench SHALL check, with FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8: memory never responds -> pixel=0 presented after the timeout and fetch_error=1 until reset; without the macro, the block stays in MEM_WAIT and fetch_error=0.

Source files
------------

// File: rtl/pixel_fetch_responder.sv
// pixel_fetch_responder: serves single-pixel requests from a frame buffer in memory; optional fetch timeout under FETCH_TIMEOUT_EN
module pixel_fetch_responder #(
  parameter int ROW_NUM = 480,
  parameter int COL_NUM = 640,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic signed [10:0] req_x,
  input  logic signed [10:0] req_y,
  output logic              waitrequest,
  output logic [7:0]        pixel,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [7:0]        mem_readdata,
  output logic              fetch_error
);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, PRESENT} state_t;
  state_t state, state_nx;
  logic signed [10:0] x_q, y_q;
  logic [7:0] data_q;
  logic oor, load_mem, timeout, waiting;
  assign oor = req_x < 0 || req_x >= COL_NUM || req_y < 0 || req_y >= ROW_NUM;
  assign waiting = state == MEM_REQ || state == MEM_WAIT;
  assign load_mem = mem_readdatavalid && (state == MEM_WAIT || (state == MEM_REQ && !mem_waitrequest));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = en ? LOOKUP : IDLE;
      LOOKUP:   state_nx = oor ? PRESENT : MEM_REQ;
      MEM_REQ:  state_nx = load_mem || timeout ? PRESENT : !mem_waitrequest ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: state_nx = load_mem || timeout ? PRESENT : MEM_WAIT;
      PRESENT:  state_nx = en ? LOOKUP : IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    waitrequest = state != PRESENT;
    mem_read = state == MEM_REQ;
    mem_address = mem_read ? BASE_ADDR + ADDR_W'($unsigned(y_q)) * ADDR_W'(COL_NUM) + ADDR_W'($unsigned(x_q)) : '0;
    pixel = data_q;
  end
  // data_q only changes on the edge into PRESENT, so it doubles as the held pixel
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
      data_q <= '0;
    end else begin
      if (state == LOOKUP) begin
        x_q <= req_x;
        y_q <= req_y;
      end
      if (load_mem) data_q <= mem_readdata;
      else if ((state == LOOKUP && oor) || timeout) data_q <= '0;
    end
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic ferr;
  assign timeout = waiting && cnt == CW'(TIMEOUT_CYCLES);
  assign fetch_error = ferr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      ferr <= 1'b0;
    end else begin
      cnt <= state_nx == MEM_REQ && state != MEM_REQ ? '0 : waiting ? cnt + 1'b1 : cnt;
      if (timeout && !load_mem) ferr <= 1'b1;
    end
`else
  // no timeout hardware; the parameter is kept so both builds share one interface
  assign timeout = waiting && TIMEOUT_CYCLES < 0;
  assign fetch_error = 1'b0;
`endif
endmodule
